// File: rtl/pimt6_result_sink.sv
// Result sink: registers scaled-product results, divides them by 2^SCALE_EXP through
// the exponent field, and queues them in a FIFO drained over an AXI-stream master port.
module pimt6_result_sink #(
    parameter int DEPTH     = 8,
    parameter int SCALE_EXP = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    input  logic [63:0]              in_data,
    input  logic                     clr,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [63:0]              m_tdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    output logic [7:0]               drop_cnt
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [10:0]     SCALE_E  = 11'(SCALE_EXP);
    localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic            s1_vld_q, s1_vld_d;
    logic [63:0]     s1_data_q, s1_data_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [7:0]      cnt_base;
    logic [63:0]     mem_q [DEPTH];

    logic [10:0]     exp_f;
    logic [63:0]     desc_data;
    logic            uf_evt;
    logic            push, pop, full, drop;

    // Descale by subtracting from the exponent; anything that would land at or below
    // the subnormal boundary is flushed to signed zero.
    always_comb begin
        exp_f     = s1_data_q[62:52];
        desc_data = s1_data_q;
        uf_evt    = 1'b0;
        if (exp_f == 11'h7FF) begin
            desc_data = s1_data_q;
        end else if (exp_f == 11'd0) begin
            desc_data = {s1_data_q[63], 63'd0};
            uf_evt    = |s1_data_q[51:0];
        end else if (exp_f <= SCALE_E) begin
            desc_data = {s1_data_q[63], 63'd0};
            uf_evt    = 1'b1;
        end else begin
            desc_data = {s1_data_q[63], exp_f - SCALE_E, s1_data_q[51:0]};
        end
    end

    assign full = (level_q == FULL_LVL);
    assign pop  = (level_q != '0) && m_tready;
    assign push = s1_vld_q && (!full || pop);
    assign drop = s1_vld_q && full && !pop;

    always_comb begin
        s1_vld_d  = in_vld;
        s1_data_d = in_data;
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d   = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
        // A flag event in the same cycle as clr wins over the clear.
        overflow_d  = (clr ? 1'b0 : overflow_q)  | drop;
        underflow_d = (clr ? 1'b0 : underflow_q) | (s1_vld_q && uf_evt);
        cnt_base    = clr ? 8'd0 : drop_cnt_q;
        drop_cnt_d  = cnt_base;
        if (drop && (cnt_base != 8'hFF)) begin
            drop_cnt_d = cnt_base + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_data_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_data_q   <= s1_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage is not reset; the output is gated by valid so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= desc_data;
        end
    end

    assign m_tvalid  = (level_q != '0);
    assign m_tdata   = m_tvalid ? mem_q[rd_ptr_q] : 64'd0;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/pimt6_result_sink.md
PIMT6_RESULT_SINK -- requirements
Module: pimt6_result_sink

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the FIFO entries; it SHALL be a power of two and at least 2.
REQ-002 The module SHALL have parameter SCALE_EXP, default 6, giving the descale exponent (divide by 2^SCALE_EXP); its range SHALL be 1..63.
REQ-003 clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_vld  input  1  valid-only result pulse from the scaled-product pipeline; there is no backpressure.
REQ-006 in_data  input  64  IEEE-754 double scaled by 2^SCALE_EXP.
REQ-007 clr  input  1  synchronous clear of the sticky flags and drop_cnt; FIFO contents are not affected.
REQ-008 m_tvalid  output  1  AXI-stream valid of the descaled result.
REQ-009 m_tready  input  1  AXI-stream ready from the downstream consumer.
REQ-010 m_tdata  output  64  descaled IEEE-754 double.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  output  1  sticky; a word was dropped because the FIFO was full.
REQ-013 underflow  output  1  sticky; a result was flushed to zero.
REQ-014 drop_cnt  output  8  saturating count of dropped words.

Function
REQ-015 Stage 1 SHALL register in_data and in_vld on every clock; only that registered copy SHALL be descaled and written to the FIFO.
REQ-016 Descaling SHALL leave the sign unchanged and SHALL operate on the exponent field E = bits[62:52].
REQ-017 If E = 2047 (Inf or NaN), the word SHALL pass through unchanged.
REQ-018 If E = 0 (zero or subnormal), the output SHALL be signed zero; underflow SHALL be set only when the mantissa is nonzero.
REQ-019 If 0 < E <= SCALE_EXP, the output SHALL be signed zero and underflow SHALL be set.
REQ-020 Otherwise, the output exponent SHALL be E - SCALE_EXP with the mantissa unchanged.
REQ-021 The FIFO write SHALL occur in the cycle after in_vld; m_tvalid SHALL assert 2 cycles after in_vld when the FIFO was empty (no bypass).
REQ-022 Pop SHALL occur when m_tvalid && m_tready; m_tdata SHALL equal the head entry and stay stable while m_tvalid && !m_tready.
REQ-023 m_tvalid SHALL equal (level != 0).
REQ-024 A simultaneous push and pop SHALL leave level unchanged, including at full and at level 1.
REQ-025 A push when level = DEPTH with no pop in the same cycle SHALL drop the word, set overflow and increment drop_cnt, which saturates at 255.
REQ-026 A push when level = DEPTH with a pop in the same cycle SHALL be accepted, with no drop.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH.
REQ-028 When clr and a new overflow or underflow event occur in the same cycle, the event SHALL win: the flag stays set and drop_cnt = 1 for an overflow.
REQ-029 The FIFO output order SHALL equal the in_vld input order.

Reset
REQ-030 While rst_n = 0: pointers, level, m_tvalid, overflow, underflow, drop_cnt and the stage-1 valid SHALL be 0; m_tdata SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all stored and in-flight words immediately (asynchronously), with no partial pop.
REQ-032 The first in_vld sampled after rst_n deasserts SHALL be handled normally.

Verification
REQ-033 in_vld pulse with in_data 0x4050000000000000 (64.0) at cycle N, m_tready = 1 -> m_tvalid at N+2 with m_tdata 0x3FF0000000000000 (1.0), and level returns to 0 at N+3.
REQ-034 m_tready = 0, 9 back-to-back pulses of values 1..9 (as doubles) -> level = 8, overflow = 1, drop_cnt = 1; then m_tready = 1 -> outputs are values 1..8 divided by 64, in order.
REQ-035 Each of these inputs -> required output and flag:
- 0x0050000000000000 -> 0x0000000000000000, underflow = 1;
- 0x8000000000000001 -> 0x8000000000000000, underflow = 1;
- 0x7FF8000000000000 -> 0x7FF8000000000000, no flag;
- 0xFFF0000000000000 -> 0xFFF0000000000000, no flag.
REQ-036 FIFO full with m_tready = 1 and in_vld continuous -> level stays 8, drop_cnt stays 0, and the sequence is unbroken.
REQ-037 rst_n pulled low at level = 5 -> m_tvalid = 0 and level = 0 within the same cycle; the next pulse after release emerges 2 cycles later.
REQ-038 clr asserted in the same cycle as an overflow drop -> overflow = 1, drop_cnt = 1; clr alone on the next cycle -> both read 0.
